// File: rtl/aes_shift_mix_stage.sv
// AES-128 round stage: ShiftRows on capture, then column-serial MixColumns.
// The final round bypasses the mix and goes straight to HOLD.
module aes_shift_mix_stage #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last_round,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MIX  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);

    logic [1:0]   state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic         last_q, last_d;
    logic [127:0] data_q, data_d;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    // Row r of column c comes from column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] d);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[7'(127 - 8 * (4 * c + r)) -: 8] =
                    d[7'(127 - 8 * (4 * ((c + r) % 4) + r)) -: 8];
            end
        end
        return o;
    endfunction

    // Only COLS_PER_CYCLE mixers exist; the column counter steers them.
    function automatic logic [127:0] mix_group(
        input logic [127:0] d,
        input logic [1:0]   col
    );
        logic [127:0] o;
        o = d;
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
            logic [1:0] idx;
            logic [6:0] hi;
            idx = col + 2'(i);
            hi = 7'd127 - {idx, 5'd0};
            o[hi -: 32] = mix_col(d[hi -: 32]);
        end
        return o;
    endfunction

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        last_d  = last_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = shift_rows(in_data);
                    last_d  = in_last_round;
                    col_d   = '0;
                    state_d = in_last_round ? HOLD : MIX;
                end
            end
            MIX: begin
                data_d = mix_group(data_q, col_q);
                col_d  = col_q + STEP;
                if (int'(col_q) + COLS_PER_CYCLE == 4) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;

endmodule

// File: tb/tb_aes_shift_mix_stage.sv
// Bench for aes_shift_mix_stage: vector table, corner sequences, random
// blocks against a byte-matrix AES reference, plus 2- and 4-column builds.
module tb_aes_shift_mix_stage;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_last_round;
    logic [127:0] in_data;
    logic         out_valid, out_ready, busy;
    logic [127:0] out_data;

    logic         iv2, ir2, ov2, b2;
    logic         iv4, ir4, ov4, b4;
    logic [127:0] pdata, od2, od4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    aes_shift_mix_stage #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last_round(in_last_round),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    aes_shift_mix_stage #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv2), .in_ready(ir2),
        .in_data(pdata), .in_last_round(1'b0),
        .out_valid(ov2), .out_ready(1'b1),
        .out_data(od2), .busy(b2)
    );

    aes_shift_mix_stage #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv4), .in_ready(ir4),
        .in_data(pdata), .in_last_round(1'b0),
        .out_valid(ov4), .out_ready(1'b1),
        .out_data(od4), .busy(b4)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // Reference built on a 4x4 byte matrix s[row][col].
    function automatic logic [127:0] ref_model(input logic [127:0] d, input bit last);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] coef [4];
        logic [127:0] o;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = d[127 - 8 * (4 * c + r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = s[r][(c + r) % 4];
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                logic [7:0] acc;
                if (last) acc = t[r][c];
                else begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++)
                        acc ^= gmul(coef[(j - r + 4) % 4], t[j][c]);
                end
                o[127 - 8 * (4 * c + r) -: 8] = acc;
            end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic run_block(input logic [127:0] d, input bit last, input int hold,
                             output logic [127:0] res, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 128'(in_ready), 128'(1));
        in_data = d;
        in_last_round = last;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data = 'x;
        in_last_round = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        res = out_data;
        repeat (hold) @(negedge clk);
        chk("hold_stable", out_data, res);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", 128'(out_valid), 128'(0));
        chk("release_retain", out_data, res);
    endtask

    typedef struct {
        logic [127:0] din;
        bit           last;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t vt [5];

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_MIX = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] FIPS_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    initial begin
        logic [127:0] res, a, b;
        int lat, l2, l4;
        logic [127:0] r2, r4;

        vt[0] = '{FIPS_IN, 1'b0, FIPS_MIX, 5};
        vt[1] = '{FIPS_IN, 1'b1, FIPS_SR, 1};
        vt[2] = '{{4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}}, 5};
        vt[3] = '{{4{32'h01010101}}, 1'b0, {4{32'h01010101}}, 5};
        vt[4] = '{{4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}}, 5};

        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = 'x;
        in_last_round = 1'b0;
        out_ready = 1'b0;
        iv2 = 1'b0;
        iv4 = 1'b0;
        pdata = '0;
        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_x_data", out_data, 128'(0));

        for (int i = 0; i < 5; i++) begin
            run_block(vt[i].din, vt[i].last, i % 3, res, lat);
            chk($sformatf("vec%0d_data", i), res, vt[i].exp);
            chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(vt[i].lat));
        end

        // Backpressure: B is presented the whole time A sits in HOLD.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        in_data = a;
        in_last_round = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = b;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        res = out_data;
        chk("bp_a_data", res, ref_model(a, 1'b0));
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("bp_stable", out_data, res);
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_valid", 128'(out_valid), 128'(1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_ready", 128'(in_ready), 128'(1));
        chk("bp_idle_busy", 128'(busy), 128'(0));
        chk("bp_not_captured", out_data, res);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_b_taken", 128'(busy), 128'(1));
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_b_data", out_data, ref_model(b, 1'b0));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset while the third column is about to be mixed.
        in_data = FIPS_IN;
        in_last_round = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 128'(busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_data", out_data, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_block(FIPS_IN, 1'b0, 0, res, lat);
        chk("post_rst_data", res, FIPS_MIX);
        chk("post_rst_lat", 128'(lat), 128'(5));

        for (int i = 0; i < 30; i++) begin
            bit lst;
            a = {$urandom, $urandom, $urandom, $urandom};
            lst = 1'($urandom_range(0, 1));
            run_block(a, lst, $urandom_range(0, 3), res, lat);
            chk("rand_data", res, ref_model(a, lst));
            chk("rand_lat", 128'(lat), 128'(lst ? 1 : 5));
        end

        for (int k = 0; k < 3; k++) begin
            pdata = (k == 0) ? FIPS_IN : {$urandom, $urandom, $urandom, $urandom};
            chk("p_ready", 128'({ir2, ir4}), 128'(2'b11));
            iv2 = 1'b1;
            iv4 = 1'b1;
            @(negedge clk);
            iv2 = 1'b0;
            iv4 = 1'b0;
            l2 = 0;
            l4 = 0;
            r2 = '0;
            r4 = '0;
            for (int n = 1; n <= 10; n++) begin
                if (ov2 && l2 == 0) begin l2 = n; r2 = od2; end
                if (ov4 && l4 == 0) begin l4 = n; r4 = od4; end
                @(negedge clk);
            end
            chk("c2_lat", 128'(l2), 128'(3));
            chk("c4_lat", 128'(l4), 128'(2));
            chk("c2_data", r2, ref_model(pdata, 1'b0));
            chk("c4_data", r4, ref_model(pdata, 1'b0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
